// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared ISA constants and PC types for the fetch stage
package fetch_pc_unit_pkg;

  localparam int PC_W     = 16;
  localparam int INSTR_W  = 16;
  localparam int OPCODE_W = 4;
  localparam int FUNCT_W  = 3;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t PC_RESET_DEFAULT = 16'h0000;

  localparam logic [OPCODE_W-1:0] OP_ALU   = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_JTYPE = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_LW    = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_SW    = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_FOR   = 4'b1000;

  typedef enum logic [FUNCT_W-1:0] {
    JF_JMP  = 3'b000,
    JF_CALL = 3'b001,
    JF_RET  = 3'b010
  } jfunct_e;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - fetch stage bundle: imem address/stall, redirect inputs, ID-side outputs
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  pc_t         imem_addr;
  logic        imem_stall;
  logic        stall_in;
  logic        br_taken;
  pc_t         br_target;
  logic        jmp_en;
  logic        call_en;
  logic        ret_en;
  pc_t         jmp_target;
  pc_t         ret_fallback;
  pc_t         id_pc;
  pc_t         id_pc_plus1;
  logic        id_valid;
  logic        ras_empty;
  logic [15:0] kill_count;

  modport master (
    output imem_addr, imem_stall, id_pc, id_pc_plus1, id_valid, ras_empty, kill_count,
    input  stall_in, br_taken, br_target, jmp_en, call_en, ret_en, jmp_target, ret_fallback
  );

  modport slave (
    input  imem_addr, imem_stall, id_pc, id_pc_plus1, id_valid, ras_empty, kill_count,
    output stall_in, br_taken, br_target, jmp_en, call_en, ret_en, jmp_target, ret_fallback
  );

endinterface

// File: rtl/fetch_pc_unit_ras_stack.sv
// rtl/fetch_pc_unit_ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack
  import fetch_pc_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output pc_t  top,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W:0]   count;
  pc_t              mem [DEPTH];

  assign empty = (count == '0);
  // ptr points at the next free slot, so the newest entry sits just below it
  assign top   = mem[ptr - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (count != FULL_COUNT) count <= count + (PTR_W + 1)'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch stage: PC register, redirect selection, wrong-path kill and ID PC/valid tracking
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter pc_t RESET_PC  = PC_RESET_DEFAULT,
  parameter int  RAS_DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  fetch_pc_unit_if.master   bus
);

  pc_t         pc_q;
  pc_t         id_pc;
  logic        id_valid;
  logic [15:0] kill_count;
  pc_t         next_target;
  pc_t         ras_top;
  logic        ras_empty;
  logic        id_redirect;
  logic        redirect;
  logic        ras_push;
  logic        ras_pop;

  // a taken branch squashes the ID instruction, so its RAS side effect is dropped too
  assign id_redirect = bus.jmp_en | bus.call_en | bus.ret_en;
  assign redirect    = bus.br_taken | id_redirect;
  assign ras_push    = bus.call_en & ~bus.br_taken;
  assign ras_pop     = bus.ret_en & ~bus.br_taken;

  always_comb begin
    next_target = pc_q + 16'd1;
    if (bus.br_taken)                  next_target = bus.br_target;
    else if (bus.jmp_en | bus.call_en) next_target = bus.jmp_target;
    else if (bus.ret_en)               next_target = ras_empty ? bus.ret_fallback : ras_top;
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (id_pc + 16'd1),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      id_pc      <= '0;
      id_valid   <= 1'b0;
      kill_count <= '0;
    end else if (redirect) begin
      pc_q       <= next_target;
      id_pc      <= pc_q;
      id_valid   <= 1'b0;
      kill_count <= kill_count + 16'd1;
    end else if (!bus.stall_in) begin
      pc_q     <= pc_q + 16'd1;
      id_pc    <= pc_q;
      id_valid <= 1'b1;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.imem_stall  = bus.stall_in & ~redirect;
  assign bus.id_pc       = id_pc;
  assign bus.id_pc_plus1 = id_pc + 16'd1;
  assign bus.id_valid    = id_valid;
  assign bus.ras_empty   = ras_empty;
  assign bus.kill_count  = kill_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed and randomized checks of fetch_pc_unit against a queue-based model
module tb_fetch_pc_unit;

  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] m_pc;
  logic [15:0] m_id_pc;
  logic        m_id_valid;
  logic [15:0] m_kill;
  logic [15:0] ras_q [$];

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (16'h0000),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("id_pc", bus.id_pc, m_id_pc);
    check("id_pc_plus1", bus.id_pc_plus1, m_id_pc + 16'd1);
    check("id_valid", 16'(bus.id_valid), 16'(m_id_valid));
    check("ras_empty", 16'(bus.ras_empty), 16'(ras_q.size() == 0));
    check("kill_count", bus.kill_count, m_kill);
    check("imem_addr", bus.imem_addr, m_pc);
  endtask

  task automatic do_reset();
    bus.stall_in = 0; bus.br_taken = 0; bus.jmp_en = 0; bus.call_en = 0; bus.ret_en = 0;
    bus.br_target = 0; bus.jmp_target = 0; bus.ret_fallback = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_pc = 16'h0000; m_id_pc = 16'h0000; m_id_valid = 1'b0; m_kill = 16'h0000;
    ras_q.delete();
    check_state();
  endtask

  // one clock: drive at negedge, check combinational outputs, advance model, check registered state
  task automatic step(input logic st, input logic br, input logic [15:0] brt,
                      input logic jmp, input logic call, input logic ret,
                      input logic [15:0] jt, input logic [15:0] fb);
    logic        redir;
    logic [15:0] tgt;
    bus.stall_in = st; bus.br_taken = br; bus.br_target = brt;
    bus.jmp_en = jmp; bus.call_en = call; bus.ret_en = ret;
    bus.jmp_target = jt; bus.ret_fallback = fb;
    redir = br | jmp | call | ret;
    if (br)               tgt = brt;
    else if (jmp || call) tgt = jt;
    else if (ret)         tgt = (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : fb;
    else                  tgt = m_pc + 16'd1;
    #1;
    check("imem_addr_pre", bus.imem_addr, m_pc);
    check("imem_stall", 16'(bus.imem_stall), 16'(st & ~redir));
    if (!br && call) begin
      ras_q.push_back(m_id_pc + 16'd1);
      if (ras_q.size() > RAS_DEPTH) ras_q.delete(0);
    end
    if (!br && ret && ras_q.size() > 0) ras_q.delete(ras_q.size() - 1);
    if (redir) begin
      m_id_pc = m_pc; m_id_valid = 1'b0; m_kill = m_kill + 16'd1; m_pc = tgt;
    end else if (!st) begin
      m_id_pc = m_pc; m_id_valid = 1'b1; m_pc = m_pc + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    bus.stall_in = 0; bus.br_taken = 0; bus.jmp_en = 0; bus.call_en = 0; bus.ret_en = 0;
    check_state();
  endtask

  task automatic free_run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("reset_pc", bus.imem_addr, 16'h0000);
    check("reset_valid", 16'(bus.id_valid), 16'h0000);

    free_run(3);
    check("run_addr3", bus.imem_addr, 16'h0003);
    check("run_id_pc2", bus.id_pc, 16'h0002);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("stall_hold", bus.imem_addr, 16'h0003);
    free_run(1);
    check("resume_addr", bus.imem_addr, 16'h0004);
    check("resume_id_pc", bus.id_pc, 16'h0003);
    step(0, 0, 0, 1, 0, 0, 16'd12, 0);
    check("jmp_kill_valid", 16'(bus.id_valid), 16'h0000);
    check("jmp_kill_count", bus.kill_count, 16'h0001);
    free_run(1);
    check("jmp_target_id", bus.id_pc, 16'd12);
    check("jmp_target_valid", 16'(bus.id_valid), 16'h0001);

    do_reset();
    free_run(1);
    step(0, 0, 0, 0, 1, 0, 16'd10, 0);
    check("call_ras_nonempty", 16'(bus.ras_empty), 16'h0000);
    free_run(2);
    check("ret_at_id11", bus.id_pc, 16'd11);
    step(0, 0, 0, 0, 0, 1, 0, 16'h0055);
    check("ret_target", bus.imem_addr, 16'h0001);
    check("ret_ras_empty", 16'(bus.ras_empty), 16'h0001);
    check("ret_kill_count", bus.kill_count, 16'h0002);

    step(1, 1, 16'd2, 0, 1, 0, 16'd40, 0);
    check("br_pc", bus.imem_addr, 16'h0002);
    check("br_no_push", 16'(bus.ras_empty), 16'h0001);
    check("br_kill_valid", 16'(bus.id_valid), 16'h0000);

    do_reset();
    free_run(1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1, 0, 16'h0100 + 16'(i * 16), 0);
      free_run(1);
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, 16'h0077);
      if (i == 4) check("ret_fallback", bus.imem_addr, 16'h0077);
      free_run(1);
    end

    step(0, 0, 0, 1, 0, 0, 16'hFFFE, 0);
    free_run(2);
    check("wrap_pc", bus.imem_addr, 16'h0000);
    check("wrap_id_pc", bus.id_pc, 16'hFFFF);
    check("wrap_plus1", bus.id_pc_plus1, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 99) do_reset();
      else step($urandom_range(0, 3) == 0, r < 8, 16'($urandom),
                r >= 8 && r < 14, r >= 14 && r < 24, r >= 24 && r < 33,
                16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the synchronous instruction memory.
- Owns the PC register and drives the memory Address and stall inputs.
- Selects the next PC from sequential, branch, jump, call and return sources, and kills the wrong-path fetch.
- Tracks PC and valid for the instruction word the memory presents to decode; a small return-address stack (RAS) supplies return targets.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address entries (power of two, at least 2).

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  16  to instruction memory Address; equals pc_q.
- imem_stall  out  1  to instruction memory stall.
- stall_in  in  1  load-use/hazard stall from decode.
- br_taken  in  1  BEQ/FOR resolved taken in EX.
- br_target  in  16  branch target.
- jmp_en  in  1  J-type jump decoded in ID.
- call_en  in  1  J-type jump-and-link decoded in ID.
- ret_en  in  1  J-type return decoded in ID.
- jmp_target  in  16  jump/call target from ID.
- ret_fallback  in  16  architectural link register value, used when RAS is empty.
- id_pc  out  16  PC of the word currently on memory output.
- id_pc_plus1  out  16  id_pc + 1.
- id_valid  out  1  memory output word is a live instruction.
- ras_empty  out  1  RAS holds no entries.
- kill_count  out  16  number of killed fetch slots, wraps at 2^16.

Behaviour:
- Reset, sampled on the clock edge while reset = 0:
  - pc_q = RESET_PC, id_pc = 0, id_valid = 0, kill_count = 0.
  - RAS pointer and count = 0, so ras_empty = 1.
  - Memory output is unreset; id_valid = 0 masks it.
  - A reset asserted mid-operation discards all pending redirects and RAS contents.
- Memory interface: imem_addr = pc_q is combinational. The memory registers the word at the edge, so there is 1-cycle fetch latency.
- Redirect priority: br_taken > (jmp_en | call_en | ret_en) > sequential. Branch wins because it is the older instruction. ID-side enables are mutually exclusive by decode; the unit does not check this.
- Redirect target:
  - br_taken → br_target.
  - jmp_en or call_en → jmp_target.
  - ret_en → RAS top if not empty, else ret_fallback.
- Per edge, with reset inactive:
  - Redirect active (overrides stall_in): pc_q ← target; id_pc ← pc_q; id_valid ← 0 (kill); kill_count += 1. imem_stall = 0 in this cycle.
  - Else stall_in = 1: pc_q, id_pc, id_valid hold; imem_stall = 1.
  - Else: pc_q ← pc_q + 1; id_pc ← pc_q; id_valid ← 1.
- Kill timing: exactly one bubble per ID-side redirect. The word fetched in the redirect cycle is presented with id_valid = 0, and the target word arrives valid on the following cycle.
- A branch from EX also invalidates the current ID word. Decode squashes it using br_taken; this unit only kills the fetch slot.
- PC arithmetic: 16-bit modulo, so 16'hFFFF + 1 = 16'h0000. id_pc_plus1 wraps the same way.
- RAS push (call_en without br_taken):
  - Pushes id_pc + 1.
  - If full, the oldest entry is overwritten (circular pointer) and count stays at RAS_DEPTH.
- RAS pop (ret_en without br_taken):
  - Pops if count > 0.
  - If empty, no state change and the target is ret_fallback.
- br_taken in the same cycle as call_en or ret_en: the ID instruction is squashed, so no RAS push or pop occurs.
- No handshake beyond stall: a word is consumed by decode on any edge where stall_in = 0 and id_valid = 1.

Decomposition:
- Shared package: opcode constants (OP_ALU = 4'b0000, OP_JTYPE = 4'b0001, OP_LW = 4'b0100, OP_SW = 4'b0101, OP_BEQ = 4'b0110, OP_FOR = 4'b1000), J-type function codes (JMP = 3'b000, CALL = 3'b001, RET = 3'b010), instruction field widths, and RESET_PC.
- Sub-module ras_stack: parameterised circular stack with push/pop/top/empty. Redirect muxing and PC/valid tracking stay in fetch_pc_unit.

Test Plan:
- Reset then free-run for 5 cycles → imem_addr 0,1,2,3,4. id_valid is 0 on the first cycle, then 1 with id_pc 0,1,2,3.
- stall_in = 1 for 2 cycles at pc_q = 3 → imem_addr stays 3, imem_stall = 1, id_pc/id_valid frozen; fetch resumes at 4.
- jmp_en with jmp_target = 12 while id_pc = 3 → next cycle id_valid = 0 and kill_count = 1; the following cycle id_pc = 12 with id_valid = 1.
- call_en at id_pc = 0 to target 10, then ret_en at id_pc = 11 → return target is 1, ras_empty goes 1→0→1, and one kill per redirect (kill_count = 2).
- br_taken (br_target = 2) together with stall_in and call_en → pc_q = 2, imem_stall = 0, no RAS push, id_valid = 0.
- Five calls with RAS_DEPTH = 4, then five returns → returns 4 through 1 come from the RAS in LIFO order; the fifth return (RAS empty) uses ret_fallback = 16'h0077. Also check PC wrap at 16'hFFFF → 0.
